// File: rtl/wvf_pkg.sv
// Shared types and default widths for the LUT waveform burst sequencer.
// The state encoding is fixed at 3 bits so downstream debug taps stay stable.
package wvf_pkg;

  localparam int CNT_WIDTH_DEF = 16;
  localparam int PER_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_FIN   = 3'd4
  } wvf_state_e;

endpackage

// File: rtl/wvf_tick_gen.sv
// Loadable modulo counter: counts 0..limit while enabled, then wraps to zero.
// wrap is high in the cycle the counter sits at limit; clr parks it at zero.
module wvf_tick_gen #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         wrap
);

  logic [W-1:0] cnt_r;

  // Counter state: clear dominates, otherwise advance modulo limit+1
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en) begin
      if (cnt_r == limit) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + W'(1'b1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign wrap = en && !clr && (cnt_r == limit);

endmodule

// File: rtl/wvf_burst_ctrl.sv
// Burst sequencer for the LUT waveform generator: N periods per burst, M bursts,
// programmable step spacing and inter-burst pause. Every output is a flop.
module wvf_burst_ctrl
  import wvf_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int PER_WIDTH = PER_WIDTH_DEF
) (
  input  logic                 CLK_SYS,
  input  logic                 nRST,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic [CNT_WIDTH-1:0] WAIT_CYC,
  input  logic [PER_WIDTH-1:0] NUM_PERIODS,
  input  logic [PER_WIDTH-1:0] NUM_BURSTS,
  input  logic [CNT_WIDTH-1:0] PAUSE_CYC,
  input  logic                 LUT_END,
  output logic                 EN_LUT,
  output logic                 TRGG_LUT,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 ERR,
  output logic [PER_WIDTH-1:0] PERIOD_CNT,
  output logic [PER_WIDTH-1:0] BURST_CNT
);

  wvf_state_e           state_r;
  wvf_state_e           state_nxt_s;

  logic [CNT_WIDTH-1:0] wait_r;
  logic [CNT_WIDTH-1:0] pause_r;
  logic [PER_WIDTH-1:0] nper_r;
  logic [PER_WIDTH-1:0] nbur_r;
  logic [PER_WIDTH-1:0] per_cnt_r;
  logic [PER_WIDTH-1:0] bur_cnt_r;

  logic [PER_WIDTH-1:0] per_cnt_nxt_s;
  logic [PER_WIDTH-1:0] bur_cnt_nxt_s;
  logic [PER_WIDTH-1:0] per_inc_s;
  logic [PER_WIDTH-1:0] bur_inc_s;
  logic [CNT_WIDTH-1:0] wait_lim_s;

  logic                 cfg_ok_s;
  logic                 cfg_load_s;
  logic                 err_nxt_s;
  logic                 en_nxt_s;
  logic                 trg_nxt_s;
  logic                 busy_nxt_s;
  logic                 done_nxt_s;

  logic                 trg_en_s;
  logic                 trg_wrap_s;
  logic                 pause_en_s;
  logic                 pause_wrap_s;

  // The step counter also runs during ARM so the first trigger lands WAIT_CYC
  // cycles after EN_LUT rises; WAIT_CYC=1 then wraps every cycle.
  assign trg_en_s   = (state_r == ST_ARM) || (state_r == ST_RUN);
  assign pause_en_s = (state_r == ST_PAUSE);
  assign wait_lim_s = wait_r - CNT_WIDTH'(1'b1);

  wvf_tick_gen #(.W(CNT_WIDTH)) u_trg_tick (
    .clk   (CLK_SYS),
    .rst_n (nRST),
    .clr   (!trg_en_s),
    .en    (trg_en_s),
    .limit (wait_lim_s),
    .wrap  (trg_wrap_s)
  );

  // Pause lasts PAUSE_CYC+1 cycles: the counter visits 0..PAUSE_CYC
  wvf_tick_gen #(.W(CNT_WIDTH)) u_pause_tick (
    .clk   (CLK_SYS),
    .rst_n (nRST),
    .clr   (!pause_en_s),
    .en    (pause_en_s),
    .limit (pause_r),
    .wrap  (pause_wrap_s)
  );

  assign cfg_ok_s  = (WAIT_CYC != '0) && (NUM_PERIODS != '0) && (NUM_BURSTS != '0);
  assign per_inc_s = per_cnt_r + PER_WIDTH'(1'b1);
  assign bur_inc_s = bur_cnt_r + PER_WIDTH'(1'b1);

  // State, config latch, counters and output flops
  always_ff @(posedge CLK_SYS) begin
    if (!nRST) begin
      state_r   <= ST_IDLE;
      wait_r    <= '0;
      pause_r   <= '0;
      nper_r    <= '0;
      nbur_r    <= '0;
      per_cnt_r <= '0;
      bur_cnt_r <= '0;
      EN_LUT    <= 1'b0;
      TRGG_LUT  <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      per_cnt_r <= per_cnt_nxt_s;
      bur_cnt_r <= bur_cnt_nxt_s;
      EN_LUT    <= en_nxt_s;
      TRGG_LUT  <= trg_nxt_s;
      BUSY      <= busy_nxt_s;
      DONE      <= done_nxt_s;
      ERR       <= err_nxt_s;
      if (cfg_load_s) begin
        wait_r  <= WAIT_CYC;
        pause_r <= PAUSE_CYC;
        nper_r  <= NUM_PERIODS;
        nbur_r  <= NUM_BURSTS;
      end else begin
        wait_r  <= wait_r;
        pause_r <= pause_r;
        nper_r  <= nper_r;
        nbur_r  <= nbur_r;
      end
    end
  end

  // Next state and counter values; ABORT outranks START and LUT_END
  always_comb begin
    state_nxt_s   = state_r;
    per_cnt_nxt_s = per_cnt_r;
    bur_cnt_nxt_s = bur_cnt_r;
    cfg_load_s    = 1'b0;
    err_nxt_s     = 1'b0;
    if (ABORT) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (START && cfg_ok_s) begin
            cfg_load_s    = 1'b1;
            per_cnt_nxt_s = '0;
            bur_cnt_nxt_s = '0;
            state_nxt_s   = ST_ARM;
          end else if (START) begin
            err_nxt_s   = 1'b1;
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_ARM: begin
          state_nxt_s = ST_RUN;
        end
        ST_RUN: begin
          if (LUT_END) begin
            per_cnt_nxt_s = per_inc_s;
            if (per_inc_s == nper_r) begin
              bur_cnt_nxt_s = bur_inc_s;
              if (bur_inc_s == nbur_r) begin
                state_nxt_s = ST_FIN;
              end else begin
                state_nxt_s = ST_PAUSE;
              end
            end else begin
              state_nxt_s = ST_RUN;
            end
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_PAUSE: begin
          if (pause_wrap_s) begin
            per_cnt_nxt_s = '0;
            state_nxt_s   = ST_ARM;
          end else begin
            state_nxt_s = ST_PAUSE;
          end
        end
        ST_FIN: begin
          state_nxt_s = ST_IDLE;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // Output values are decoded from the state about to be entered
  always_comb begin
    en_nxt_s   = 1'b0;
    trg_nxt_s  = 1'b0;
    busy_nxt_s = 1'b1;
    done_nxt_s = 1'b0;
    case (state_nxt_s)
      ST_IDLE: begin
        busy_nxt_s = 1'b0;
      end
      ST_ARM: begin
        en_nxt_s = 1'b1;
      end
      ST_RUN: begin
        en_nxt_s  = 1'b1;
        trg_nxt_s = trg_wrap_s;
      end
      ST_PAUSE: begin
        busy_nxt_s = 1'b1;
      end
      ST_FIN: begin
        done_nxt_s = 1'b1;
      end
      default: begin
        busy_nxt_s = 1'b0;
      end
    endcase
  end

  assign PERIOD_CNT = per_cnt_r;
  assign BURST_CNT  = bur_cnt_r;

endmodule

// File: tb/tb_wvf_burst_ctrl.sv
// Directed bench for wvf_burst_ctrl: inputs change 1 ns after the rising edge,
// outputs are sampled at that same point, i.e. well away from the active edge.
module tb_wvf_burst_ctrl;

  localparam int CW = 16;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          nrst;
  logic          start;
  logic          abort;
  logic          lut_end;
  logic [CW-1:0] wait_cyc;
  logic [CW-1:0] pause_cyc;
  logic [PW-1:0] num_periods;
  logic [PW-1:0] num_bursts;
  logic          en_lut;
  logic          trgg_lut;
  logic          busy;
  logic          done;
  logic          err;
  logic [PW-1:0] period_cnt;
  logic [PW-1:0] burst_cnt;

  int checks   = 0;
  int failures = 0;

  logic [CW-1:0] bad_w  [3] = '{16'd0, 16'd4, 16'd4};
  logic [PW-1:0] bad_np [3] = '{8'd2, 8'd0, 8'd2};
  logic [PW-1:0] bad_nb [3] = '{8'd1, 8'd1, 8'd0};

  always #5 clk = ~clk;

  wvf_burst_ctrl #(.CNT_WIDTH(CW), .PER_WIDTH(PW)) dut (
    .CLK_SYS     (clk),
    .nRST        (nrst),
    .START       (start),
    .ABORT       (abort),
    .WAIT_CYC    (wait_cyc),
    .NUM_PERIODS (num_periods),
    .NUM_BURSTS  (num_bursts),
    .PAUSE_CYC   (pause_cyc),
    .LUT_END     (lut_end),
    .EN_LUT      (en_lut),
    .TRGG_LUT    (trgg_lut),
    .BUSY        (busy),
    .DONE        (done),
    .ERR         (err),
    .PERIOD_CNT  (period_cnt),
    .BURST_CNT   (burst_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [CW-1:0] w, input logic [PW-1:0] np,
                     input logic [PW-1:0] nb, input logic [CW-1:0] p);
    wait_cyc    = w;
    num_periods = np;
    num_bursts  = nb;
    pause_cyc   = p;
  endtask

  // {EN_LUT, TRGG_LUT, BUSY, DONE, ERR}
  function automatic logic [4:0] flags();
    return {en_lut, trgg_lut, busy, done, err};
  endfunction

  function automatic logic [15:0] counts();
    return {period_cnt, burst_cnt};
  endfunction

  initial begin
    int       windows;
    int       gap;
    int       en_age;
    int       done_cnt;
    int       gap_trg;
    logic     prev_en;
    logic     seen;
    logic [7:0] exp_per;

    nrst = 1'b0; start = 1'b0; abort = 1'b0; lut_end = 1'b0;
    cfg(16'd0, 8'd0, 8'd0, 16'd0);

    // Reset state
    step(); step();
    chk("reset_flags", flags(), 5'b00000);
    chk("reset_counts", counts(), 16'h0000);
    nrst = 1'b1;
    step();

    // Basic run: W=4, 2 periods, 1 burst; config scrambled after latching
    cfg(16'd4, 8'd2, 8'd1, 16'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    cfg(16'd2, 8'd1, 8'd5, 16'd3);
    chk("basic_arm", flags(), 5'b10100);
    for (int o = 1; o <= 64; o++) begin
      step();
      lut_end = 1'b0;
      exp_per = (o > 32) ? 8'd1 : 8'd0;
      chk($sformatf("basic_run_o%0d", o), {flags(), period_cnt},
          {1'b1, ((o % 4) == 0), 1'b1, 1'b0, 1'b0, exp_per});
      if (o == 32 || o == 64) lut_end = 1'b1;
    end
    step();
    lut_end = 1'b0;
    chk("basic_fin_flags", flags(), 5'b00110);
    chk("basic_fin_counts", counts(), {8'd2, 8'd1});
    step();
    chk("basic_idle_flags", flags(), 5'b00000);
    chk("basic_idle_counts", counts(), {8'd2, 8'd1});

    // Multi-burst: three windows separated by PAUSE_CYC+1 = 11 idle cycles
    cfg(16'd2, 8'd1, 8'd3, 16'd10);
    start = 1'b1;
    windows = 0; gap = 0; en_age = 0; done_cnt = 0; gap_trg = 0; prev_en = 1'b0;
    for (int c = 0; c < 60; c++) begin
      step();
      start = 1'b0;
      lut_end = 1'b0;
      if (en_lut) begin
        if (!prev_en) begin
          windows++;
          en_age = 0;
          chk($sformatf("mb_arm_counts_w%0d", windows), counts(), {8'd0, 8'(windows - 1)});
          if (windows > 1) chk($sformatf("mb_gap_w%0d", windows), gap, 11);
          gap = 0;
        end else begin
          en_age++;
        end
        if (en_age == 3) lut_end = 1'b1;
      end else begin
        if (windows > 0 && busy && !done) gap++;
        if (windows > 0 && trgg_lut) gap_trg++;
      end
      if (done) done_cnt++;
      prev_en = en_lut;
    end
    chk("mb_windows", windows, 3);
    chk("mb_done_count", done_cnt, 1);
    chk("mb_gap_triggers", gap_trg, 0);
    chk("mb_final_counts", counts(), {8'd1, 8'd3});

    // Bad configurations are rejected with a one-cycle ERR
    for (int i = 0; i < 3; i++) begin
      cfg(bad_w[i], bad_np[i], bad_nb[i], 16'd0);
      start = 1'b1;
      step();
      start = 1'b0;
      chk($sformatf("bad_cfg%0d_err", i), flags(), 5'b00001);
      step();
      chk($sformatf("bad_cfg%0d_after", i), flags(), 5'b00000);
    end
    chk("bad_cfg_counts_held", counts(), {8'd1, 8'd3});

    // Abort mid-run, in the cycle a trigger would otherwise be issued
    cfg(16'd3, 8'd5, 8'd2, 16'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    lut_end = 1'b1;
    step();
    lut_end = 1'b0;
    chk("abort_pre_counts", counts(), {8'd1, 8'd0});
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_flags", flags(), 5'b00000);
    chk("abort_counts", counts(), {8'd1, 8'd0});
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      seen = seen | busy | done | en_lut;
    end
    chk("abort_quiet", seen, 1'b0);

    // Abort together with START and a completing LUT_END
    cfg(16'd3, 8'd1, 8'd1, 16'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    start = 1'b1; lut_end = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; lut_end = 1'b0; abort = 1'b0;
    chk("abort_combo_flags", flags(), 5'b00000);
    chk("abort_combo_counts", counts(), {8'd0, 8'd0});
    step();
    chk("abort_combo_after", flags(), 5'b00000);

    // Reset during PAUSE
    cfg(16'd2, 8'd1, 8'd2, 16'd10);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    lut_end = 1'b1;
    step();
    lut_end = 1'b0;
    chk("rst_pause_flags", flags(), 5'b00100);
    chk("rst_pause_counts", counts(), {8'd1, 8'd1});
    step(); step();
    nrst = 1'b0;
    step();
    chk("rst_mid_flags", flags(), 5'b00000);
    chk("rst_mid_counts", counts(), 16'h0000);
    nrst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      seen = seen | busy | done | en_lut;
    end
    chk("rst_stays_idle", seen, 1'b0);

    // START while busy (with an otherwise invalid config) is ignored
    cfg(16'd4, 8'd1, 8'd1, 16'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    start = 1'b1;
    wait_cyc = 16'd0;
    step();
    start = 1'b0;
    chk("busy_start_o3", flags(), 5'b10100);
    step();
    chk("busy_start_trg_o4", flags(), 5'b11100);
    lut_end = 1'b1;
    step();
    lut_end = 1'b0;
    chk("busy_start_fin", flags(), 5'b00110);
    chk("busy_start_counts", counts(), {8'd1, 8'd1});
    step();
    chk("busy_start_idle", flags(), 5'b00000);

    // WAIT_CYC=1: trigger every RUN cycle, LUT_END coincides with triggers
    cfg(16'd1, 8'd2, 8'd1, 16'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("w1_arm", flags(), 5'b10100);
    for (int o = 1; o <= 6; o++) begin
      step();
      lut_end = 1'b0;
      exp_per = (o > 3) ? 8'd1 : 8'd0;
      chk($sformatf("w1_run_o%0d", o), {flags(), period_cnt}, {5'b11100, exp_per});
      if (o == 3 || o == 6) lut_end = 1'b1;
    end
    step();
    lut_end = 1'b0;
    chk("w1_fin_flags", flags(), 5'b00110);
    chk("w1_fin_counts", counts(), {8'd2, 8'd1});
    step();
    chk("w1_idle", flags(), 5'b00000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wvf_burst_ctrl.md
Name: wvf_burst_ctrl

Overview:
- Sequencer for the LUT waveform generator (LUT_WVF_GEN family). Drives its EN and TRGG_CNT_FLAG inputs and counts its LUT_END flags.
- Produces bursts of N full waveform periods at a programmable step rate, separated by a programmable pause, repeated M times.
- Sits between the register/host interface and the generator. Replaces the hand-timed trigger loop currently done in benches.

Parameters:
- CNT_WIDTH, 16, width of WAIT_CYC, PAUSE_CYC and the internal tick/pause counters.
- PER_WIDTH, 8, width of NUM_PERIODS, NUM_BURSTS and the period/burst counters.

Ports:
- CLK_SYS  in  1  system clock; all logic on the rising edge.
- nRST  in  1  reset, synchronous, active-low.
- START  in  1  one-cycle request; latches the config and begins the sequence.
- ABORT  in  1  one-cycle request; stops immediately.
- WAIT_CYC  in  CNT_WIDTH  clock cycles between LUT steps (trigger spacing).
- NUM_PERIODS  in  PER_WIDTH  waveform periods per burst.
- NUM_BURSTS  in  PER_WIDTH  bursts per sequence.
- PAUSE_CYC  in  CNT_WIDTH  idle cycles between bursts.
- LUT_END  in  1  generator end-of-period flag; one cycle per period.
- EN_LUT  out  1  generator enable.
- TRGG_LUT  out  1  one-cycle step trigger to the generator.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse on normal completion.
- ERR  out  1  one-cycle pulse when START is rejected.
- PERIOD_CNT  out  PER_WIDTH  periods completed in the current burst.
- BURST_CNT  out  PER_WIDTH  bursts completed.

Behaviour:
- Reset:
  - nRST=0 sampled on an edge forces state IDLE and clears every output and counter (all 0).
  - Reset mid-burst behaves identically; no DONE pulse is produced.
- All outputs are registered.
- FSM states: IDLE, ARM, RUN, PAUSE, FIN.
- IDLE:
  - On START=1: if any of WAIT_CYC, NUM_PERIODS, NUM_BURSTS is 0, pulse ERR next cycle and stay IDLE.
  - Otherwise latch all four config inputs and clear PERIOD_CNT and BURST_CNT, then go to ARM.
  - Config inputs are ignored after latching.
- ARM:
  - Lasts 1 cycle. EN_LUT=1, BUSY=1, tick counter cleared. Next state RUN.
  - START at cycle n gives EN_LUT=1 and BUSY=1 from cycle n+1.
- RUN, step triggers:
  - EN_LUT=1. The tick counter increments each cycle and wraps at WAIT_CYC-1.
  - TRGG_LUT is high for the cycle following the wrap.
  - First TRGG_LUT comes exactly WAIT_CYC cycles after EN_LUT rises, then one every WAIT_CYC cycles.
  - WAIT_CYC=1 holds TRGG_LUT continuously high.
- RUN, period counting:
  - Each LUT_END=1 increments PERIOD_CNT.
  - When the increment reaches NUM_PERIODS, increment BURST_CNT.
  - If BURST_CNT reaches NUM_BURSTS, go to FIN; otherwise go to PAUSE.
  - TRGG_LUT and EN_LUT drop in the cycle after that LUT_END.
  - LUT_END coinciding with a trigger: the trigger is still issued, then the state change applies.
- PAUSE:
  - EN_LUT=0, TRGG_LUT=0. Count PAUSE_CYC cycles, then go to ARM.
  - ARM clears PERIOD_CNT on re-entry from PAUSE.
  - PAUSE_CYC=0 goes to ARM in the next cycle (single-cycle PAUSE).
- FIN:
  - 1 cycle. DONE=1, BUSY=1, EN_LUT=0. Next state IDLE.
  - PERIOD_CNT and BURST_CNT keep their final values until the next accepted START.
- ABORT:
  - ABORT=1 in any non-IDLE state goes to IDLE next cycle.
  - EN_LUT, TRGG_LUT and BUSY go to 0 in that cycle. No DONE pulse; counters are held.
  - ABORT takes priority over START and LUT_END in the same cycle.
- START while BUSY is ignored (no ERR).
- LUT_END outside RUN is ignored.
- Counters are compared with ==. The latched limits are ≥1, so no wrap-around is possible.

Decomposition:
- Shared package wvf_pkg holds:
  - FSM state typedef (IDLE/ARM/RUN/PAUSE/FIN, 3-bit encoding).
  - CNT_WIDTH and PER_WIDTH defaults.
- One natural sub-module: wvf_tick_gen.
  - Loadable modulo counter, clear input, one-cycle wrap pulse.
  - Reused for both trigger pacing (modulo WAIT_CYC) and the pause countdown.

Test Plan:
- Reset and basic run: reset, then START with WAIT_CYC=4, NUM_PERIODS=2, NUM_BURSTS=1, PAUSE_CYC=0.
  - EN_LUT high at n+1; TRGG_LUT every 4 cycles.
  - Stub LUT_END after 8 triggers gives PERIOD_CNT=1; after 16 triggers gives PERIOD_CNT=2.
  - Next cycle: EN_LUT=0 and DONE=1 for one cycle, BURST_CNT=1.
- Multi-burst: NUM_BURSTS=3, PAUSE_CYC=10 -> three EN_LUT windows, each gap exactly 10+1 cycles with EN_LUT=0 and no triggers; DONE once, BURST_CNT=3.
- Bad config: START with WAIT_CYC=0 -> ERR pulse 1 cycle, BUSY stays 0. Repeat with NUM_PERIODS=0 and NUM_BURSTS=0; each gives the same result.
- Abort mid-run: ABORT during RUN, or in the same cycle as START+LUT_END -> next cycle IDLE, EN_LUT=0, TRGG_LUT=0, DONE never asserted, counters held.
- Reset mid-operation and START while BUSY:
  - nRST=0 during PAUSE -> all outputs 0 next cycle.
  - START while BUSY does not restart the sequence and raises no ERR.
- WAIT_CYC=1 edge case with LUT_END coinciding with a trigger -> TRGG_LUT continuously high during RUN; the coincident trigger is issued, then RUN exits correctly.
